rns_503_512_decoder: RTL and testbench



---
 rtl/mod503_pkg.sv | 25 ++
 rtl/rns_503_512_decoder_mul.sv | 82 ++++++++
 rtl/rns_503_512_decoder.sv | 165 ++++++++++++++++
 tb/tb_rns_503_512_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mod503_pkg.sv
// Shared constants, FSM state type and helpers for the {503, 512} residue decoder.
// W     : residue width; the second modulus is 2^W
// MOD_A : first (odd) modulus
// INV_A : inverse of MOD_A modulo 2^W
// OW    : width of the reconstructed value
package mod503_pkg;

    localparam int unsigned W     = 9;
    localparam int unsigned MOD_A = 503;
    localparam int unsigned INV_A = 455;
    localparam int unsigned OW    = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_T = 2'd1,
        MUL_X = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Largest X the residue pair can represent: MOD_A * 2^W - 1.
    function automatic logic [OW-1:0] max_x();
        return OW'(MOD_A * (32'd1 << W) - 32'd1);
    endfunction

endpackage

// File: rtl/rns_503_512_decoder_mul.sv
// serial_shift_add_mul: LSB-first shift-add multiplier, one multiplier bit per clock.
// The product is kept to PW bits, so a PW narrower than the full product truncates.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               load operands (ignored while busy)
//   mcand, mplier       multiplicand (PW bits) and multiplier (MW bits)
//   acc_init            starting accumulator value (lets the caller fold in an addend)
//   busy                registered, high while bits are being accumulated
//   done_c              combinational, the coming edge accumulates the final bit
//   acc_next_c          combinational, accumulator value after the coming edge
module serial_shift_add_mul #(
    parameter int unsigned MW = 9,
    parameter int unsigned PW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] mcand,
    input  logic [MW-1:0] mplier,
    input  logic [PW-1:0] acc_init,
    output logic          busy,
    output logic          done_c,
    output logic [PW-1:0] acc_next_c
);

    localparam int unsigned CW = (MW > 1) ? $clog2(MW) : 1;

    logic          busy_q,   busy_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [PW-1:0] acc_q,    acc_d;
    logic [PW-1:0] mcand_q,  mcand_d;
    logic [MW-1:0] mplier_q, mplier_d;
    logic [PW-1:0] term_c;

    // Partial product for the current bit and the load/accumulate sequencing.
    always_comb begin
        term_c     = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
        acc_next_c = acc_q + term_c;
        done_c     = (cnt_q == CW'(MW - 1));

        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;

        if (!busy_q) begin
            if (start) begin
                busy_d   = 1'b1;
                cnt_d    = '0;
                acc_d    = acc_init;
                mcand_d  = mcand;
                mplier_d = mplier;
            end
        end else begin
            acc_d = acc_next_c;
            cnt_d = cnt_q + CW'(1);
            if (done_c) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/rns_503_512_decoder.sv
// rns_503_512_decoder: residue pair (X mod 503, X mod 512) -> X by mixed-radix conversion.
//   t = ((rb - ra) mod 2^W) * INV_A mod 2^W, then X = ra + MOD_A * t.
// Two serial multipliers run back to back; the result appears 2W edges after acceptance.
// Optional build macro RANGE_CHECK_EN: flags ra >= MOD_A on out_err and zeroes out_data.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid, in_ready             input handshake
//   in_ra, in_rb                   residues mod MOD_A and mod 2^W
//   out_valid, out_ready           output handshake, result held until accepted
//   out_data                       reconstructed X
//   out_err                        out-of-range ra (RANGE_CHECK_EN builds only)
module rns_503_512_decoder
    import mod503_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_ra,
    input  logic [W-1:0]  in_rb,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_err
);

    state_e        state_q,     state_d;
    logic [W-1:0]  ra_q,        ra_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [OW-1:0] out_data_q,  out_data_d;

    logic          accept_c;
    logic [W-1:0]  d_c;
    logic          t_busy, t_done_c, x_busy, x_done_c;
    logic          x_start_c;
    logic [W-1:0]  t_next_c;
    logic [OW-1:0] x_next_c;

    assign accept_c  = in_valid & in_ready_q;
    assign d_c       = in_rb - in_ra;
    assign x_start_c = (state_q == MUL_T) & t_busy & t_done_c;

    // t = d * INV_A, truncated to W bits.
    serial_shift_add_mul #(.MW(W), .PW(W)) u_mul_t (
        .clk        (clk),
        .rst        (rst),
        .start      (accept_c),
        .mcand      (d_c),
        .mplier     (W'(INV_A)),
        .acc_init   ('0),
        .busy       (t_busy),
        .done_c     (t_done_c),
        .acc_next_c (t_next_c)
    );

    // X = ra + MOD_A * t; the ra addend is preloaded into the accumulator.
    serial_shift_add_mul #(.MW(W), .PW(OW)) u_mul_x (
        .clk        (clk),
        .rst        (rst),
        .start      (x_start_c),
        .mcand      (OW'(MOD_A)),
        .mplier     (t_next_c),
        .acc_init   (OW'(ra_q)),
        .busy       (x_busy),
        .done_c     (x_done_c),
        .acc_next_c (x_next_c)
    );

`ifdef RANGE_CHECK_EN
    logic err_q,     err_d;
    logic out_err_q, out_err_d;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef RANGE_CHECK_EN
        err_d       = err_q;
        out_err_d   = out_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    ra_d       = in_ra;
                    in_ready_d = 1'b0;
                    state_d    = MUL_T;
`ifdef RANGE_CHECK_EN
                    err_d      = (in_ra >= W'(MOD_A));
`endif
                end
            end
            MUL_T: begin
                if (x_start_c) begin
                    state_d = MUL_X;
                end
            end
            MUL_X: begin
                if (x_busy && x_done_c) begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef RANGE_CHECK_EN
                    out_data_d  = err_q ? '0 : x_next_c;
                    out_err_d   = err_q;
`else
                    out_data_d  = x_next_c;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
`ifdef RANGE_CHECK_EN
                    out_err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ra_q        <= ra_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef RANGE_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rns_503_512_decoder.sv
// Self-checking bench for rns_503_512_decoder: directed cases, a held-output case,
// a mid-conversion reset, then randomized residue pairs with random output backpressure.
// Expected X is found by searching the values congruent to rb mod 512 for the one
// congruent to ra mod 503.
module tb_rns_503_512_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_ra;
    logic [8:0]  in_rb;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        out_err;

    rns_503_512_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    // Reference: unique X in [0, 503*512) with X%503==ra and X%512==rb.
    function automatic int unsigned crt(input int unsigned ra, input int unsigned rb);
        for (int unsigned k = 0; k < 503; k++) begin
            if (((rb + 512 * k) % 503) == ra) return rb + 512 * k;
        end
        return 0;
    endfunction

    // ---------------- compare process ----------------
    int          cyc       = 0;
    int          acc_cyc   = 0;
    bit          in_flight = 0;
    bit          seen      = 0;
    bit          rdy_exp   = 0;
    bit          chk_data  = 0;
    int unsigned exp_data  = 0;
    int unsigned exp_err   = 0;
    int          n_done    = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            check("rst_in_ready",  32'(in_ready),  1);
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_out_data",  32'(out_data),  0);
            check("rst_out_err",   32'(out_err),   0);
            in_flight = 0;
            seen      = 0;
            rdy_exp   = 0;
        end else begin
            if (rdy_exp) begin
                check("in_ready_after_handshake", 32'(in_ready), 1);
                rdy_exp = 0;
            end
            if (in_flight && !seen) begin
                if (out_valid) begin
                    check("latency", 32'(cyc - acc_cyc), 18);
                    seen = 1;
                end else if (cyc - acc_cyc > 18) begin
                    check("result_timeout", 0, 1);
                    in_flight = 0;
                end
            end else if (!in_flight) begin
                if (out_valid) check("spurious_out_valid", 32'(out_valid), 0);
            end
            if (in_flight && seen) begin
                check("out_valid_held", 32'(out_valid), 1);
                check("in_ready_busy", 32'(in_ready), 0);
                check("out_err", 32'(out_err), exp_err);
                if (chk_data) check("out_data", 32'(out_data), exp_data);
                if (out_ready) begin
                    in_flight = 0;
                    seen      = 0;
                    rdy_exp   = 1;
                    n_done++;
                end
            end
            if (in_valid && in_ready) begin
                in_flight = 1;
                seen      = 0;
                acc_cyc   = cyc + 1;
`ifdef RANGE_CHECK_EN
                exp_err  = (32'(in_ra) >= 503) ? 1 : 0;
                exp_data = (exp_err != 0) ? 0 : crt(32'(in_ra), 32'(in_rb));
                chk_data = 1;
`else
                exp_err  = 0;
                chk_data = (32'(in_ra) < 503);
                exp_data = chk_data ? crt(32'(in_ra), 32'(in_rb)) : 0;
`endif
            end
        end
    end

    // ---------------- driver ----------------
    bit rand_bp  = 0;
    int n_expect = 0;

    task automatic send(input logic [8:0] a, input logic [8:0] b);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
        if (!in_ready) begin
            check("send_timeout", 0, 1);
            return;
        end
        in_ra    = a;
        in_rb    = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_expect++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && !out_valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(in_ready && !out_valid)) check("idle_timeout", 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ra     = '0;
        in_rb     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed anchors for the reference model.
        check("model_0",      crt(0, 0),     0);
        check("model_1000",   crt(497, 488), 1000);
        check("model_max",    crt(502, 511), 257535);
        check("model_503",    crt(0, 503),   503);
        check("model_1",      crt(1, 1),     1);

        send(9'd0,   9'd0);
        send(9'd497, 9'd488);
        send(9'd502, 9'd511);
        wait_idle();

        // Output held under backpressure; in_valid while busy is ignored.
        out_ready = 1'b0;
        send(9'd0, 9'd503 - 9'd0);
        for (int i = 0; i < 28; i++) begin
            in_valid = (i % 3) == 0;
            in_ra    = 9'd5;
            in_rb    = 9'd7;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("held_data", 32'(out_data), 503);
        check("held_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        wait_idle();

        // Reset part-way through a conversion.
        send(9'd100, 9'd200);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        n_expect--;
        @(posedge clk);
        #1 rst = 1'b0;
        send(9'd1, 9'd1);
        wait_idle();

`ifdef RANGE_CHECK_EN
        send(9'd503, 9'd0);
        send(9'd511, 9'd3);
        wait_idle();
`endif

        rand_bp = 1;
        for (int i = 0; i < 40; i++) begin
`ifdef RANGE_CHECK_EN
            send(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
`else
            send(9'($urandom_range(0, 502)), 9'($urandom_range(0, 511)));
`endif
        end
        rand_bp   = 0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) @(posedge clk);

        check("results_seen", 32'(n_done), 32'(n_expect));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
